sfq_toggle_rx: RTL

SFQ_TOGGLE_RX -- requirements
Module: sfq_toggle_rx

---
 rtl/sfq_toggle_rx_pkg.sv | 19 +
 rtl/sfq_toggle_detect.sv | 30 +++
 rtl/sfq_toggle_rx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sfq_toggle_rx_pkg.sv
// Shared types and default parameters for the SFQ toggle-encoded receiver.
// The state set is deliberately minimal: normal reception, or parked after a timing violation.
package sfq_toggle_rx_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_CT_CYCLES   = 2;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } rx_state_t;

  // Timer only needs to count up to CT_CYCLES and then saturate.
  function automatic int timer_width(input int ct_cycles);
    return (ct_cycles < 1) ? 1 : $clog2(ct_cycles + 1);
  endfunction

endpackage

// File: rtl/sfq_toggle_detect.sv
// Synchronizes one toggle-encoded SFQ line and turns every edge on it into a one-cycle strobe.
// The strobe is registered, so an input edge shows up as a strobe SYNC_STAGES+1 clk edges later.
module sfq_toggle_detect
  import sfq_toggle_rx_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic strobe
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // History resets to 0 so a line held high through reset still produces one strobe afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      strobe <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line};
      hist_q <= sync_q[SYNC_STAGES-1];
      strobe <= sync_q[SYNC_STAGES-1] ^ hist_q;
    end
  end

endmodule

// File: rtl/sfq_toggle_rx.sv
// SFQ toggle-encoded receiver: din edges mark a 1 for the next bit, clkin edges clock a bit in.
// Completed words go to a valid/ready holding register; timing violations park the block in FAULT.
module sfq_toggle_rx
  import sfq_toggle_rx_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int CT_CYCLES   = DEF_CT_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             clkin,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic             ovf,
  input  logic             err_clr
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam int                TMR_W    = timer_width(CT_CYCLES);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [TMR_W-1:0]  CT_SAT   = TMR_W'(CT_CYCLES);

  logic             din_stb;
  logic             clk_stb;

  rx_state_t        state_q;
  logic             data_pend_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [TMR_W-1:0] ct_tmr_q;

  logic             running;
  logic             ct_early;
  logic             bit_take;
  logic             violation;
  logic             word_done;
  logic             out_accept;
  logic             xfer;
  logic [WIDTH-1:0] next_word;

  sfq_toggle_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_din_detect (
    .clk   (clk),
    .rst   (rst),
    .line  (din),
    .strobe(din_stb)
  );

  sfq_toggle_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_clkin_detect (
    .clk   (clk),
    .rst   (rst),
    .line  (clkin),
    .strobe(clk_stb)
  );

  // ct_tmr_q holds cycles since the last accepted clkin strobe, saturating at CT_CYCLES.
  assign running    = (state_q == RUN);
  assign ct_early   = clk_stb && (ct_tmr_q < CT_SAT);
  assign bit_take   = running && clk_stb && !ct_early && !err_clr;
  assign violation  = running && clk_stb && (ct_early || din_stb);
  assign word_done  = bit_take && (bit_cnt_q == LAST_BIT);
  assign next_word  = {shreg_q[WIDTH-2:0], data_pend_q};
  assign out_accept = out_valid && out_ready;
  assign xfer       = word_done && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      data_pend_q <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      ct_tmr_q    <= CT_SAT;
      out_data    <= '0;
      out_valid   <= 1'b0;
      err         <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      // The output handshake keeps running in FAULT so a pending word can still drain.
      if (xfer) begin
        out_data  <= next_word;
        out_valid <= 1'b1;
      end else if (out_accept) begin
        out_valid <= 1'b0;
      end

      if (bit_take) begin
        ct_tmr_q <= TMR_W'(1);
      end else if (ct_tmr_q < CT_SAT) begin
        ct_tmr_q <= ct_tmr_q + TMR_W'(1);
      end

      if (err_clr) begin
        state_q     <= RUN;
        err         <= 1'b0;
        ovf         <= 1'b0;
        bit_cnt_q   <= '0;
        shreg_q     <= '0;
        data_pend_q <= 1'b0;
      end else if (running) begin
        if (violation) begin
          err     <= 1'b1;
          state_q <= FAULT;
        end
        if (bit_take) begin
          shreg_q   <= next_word;
          bit_cnt_q <= word_done ? '0 : bit_cnt_q + CNT_W'(1);
          if (word_done && out_valid && !out_ready) begin
            ovf <= 1'b1;
          end
        end
        // A din strobe coinciding with a clkin strobe belongs to the following bit.
        if (din_stb) begin
          data_pend_q <= 1'b1;
        end else if (bit_take) begin
          data_pend_q <= 1'b0;
        end
      end
    end
  end

endmodule
